// File: rtl/frame_feeder_pkg.sv
// Shared constants and types for the TAS frame feeder.
// Idle byte, default latch synchroniser depth, latch event bundle.
package frame_feeder_pkg;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;
  localparam int SYNC_DEFAULT = 2;

  typedef struct packed {
    logic rise;
    logic fall;
  } latch_ev_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with clear and occupancy level.
// Ports: clk, rst_n, clr, wr_en/wr_data, rd_en/rd_data, full, empty, level.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Extra pointer MSB tells full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign wr_ok = wr_en & ~full & ~clr;
  assign rd_ok = rd_en & ~empty & ~clr;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/frame_feeder.sv
// Packs host bytes into frames, queues them, presents one per latch.
// Ports: host byte handshake, flush, async latch_in, next_frame, status.
module frame_feeder
  import frame_feeder_pkg::*;
#(
  parameter int FRAME_BITS  = 16,
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             host_data,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   flush,
  input  logic                   latch_in,
  output logic [FRAME_BITS-1:0]  next_frame,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underflow,
  output logic [15:0]            latch_count
);

  localparam int NB = FRAME_BITS / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [FRAME_BITS-1:0] IDLE = {NB{IDLE_BYTE}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   latch_s;
  latch_ev_t              ev;

  logic [FRAME_BITS-1:0]  acc;
  logic [FRAME_BITS-1:0]  frame_w;
  logic [CW-1:0]          cnt;
  logic                   accept;
  logic                   last;

  logic                   primed;
  logic                   full;
  logic                   empty;
  logic                   wr_en;
  logic                   rd_en;
  logic                   pop_fall;
  logic                   prime;
  logic [FRAME_BITS-1:0]  rd_data;

  assign latch_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], latch_in};
      prev_q <= latch_s;
    end
  end

  always_comb begin
    ev = '0;
    ev.rise = latch_s & ~prev_q;
    ev.fall = ~latch_s & prev_q;
  end

  assign host_ready = ~full;
  assign accept = host_valid & ~full & ~flush;
  assign last = (cnt == CW'(NB - 1));
  assign frame_w = (acc << 8) | FRAME_BITS'(host_data);
  assign wr_en = accept & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= frame_w;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Priming waits for latch low so the frame never moves mid-latch.
  assign pop_fall = ev.fall & primed & ~empty;
  assign prime    = ~primed & ~empty & ~latch_s;
  assign rd_en    = ~flush & (pop_fall | prime);

  sync_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (wr_en),
    .wr_data (frame_w),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_frame  <= IDLE;
      primed      <= 1'b0;
      underflow   <= 1'b0;
      latch_count <= '0;
    end else if (flush) begin
      next_frame  <= IDLE;
      primed      <= 1'b0;
      underflow   <= 1'b0;
      latch_count <= '0;
    end else begin
      if (ev.rise) latch_count <= latch_count + 16'd1;
      if (rd_en) begin
        next_frame <= rd_data;
        primed     <= 1'b1;
      end else if (ev.fall & primed) begin
        next_frame <= IDLE;
        underflow  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_feeder.sv
// Randomised and directed bench for frame_feeder.
// Queue-based reference model checked every cycle plus directed cases.
module tb_frame_feeder;

  localparam int FB  = 16;
  localparam int DEP = 64;
  localparam int SS  = 2;
  localparam int NB  = FB / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    host_data = '0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic          flush = 1'b0;
  logic          latch_in = 1'b0;
  logic [FB-1:0] next_frame;
  logic [6:0]    level;
  logic          underflow;
  logic [15:0]   latch_count;

  int n_chk = 0;
  int n_err = 0;

  frame_feeder #(
    .FRAME_BITS  (FB),
    .DEPTH       (DEP),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_data   (host_data),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .flush       (flush),
    .latch_in    (latch_in),
    .next_frame  (next_frame),
    .level       (level),
    .underflow   (underflow),
    .latch_count (latch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the pin is seen SS edges late; events act on the
  // frame queue, pops see the queue as it stood before this edge.
  bit [FB-1:0] mq[$];
  bit [7:0]    mb[$];
  bit          hist[SS];
  bit          m_prev, m_primed, m_under;
  bit [FB-1:0] m_nf;
  bit [15:0]   m_cnt;
  bit          ls, was_full, was_empty;
  bit [FB-1:0] f;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mb.delete();
      foreach (hist[i]) hist[i] = 1'b0;
      m_prev = 0;
      m_primed = 0;
      m_under = 0;
      m_nf = '1;
      m_cnt = 0;
    end else begin
      ls = hist[SS-1];
      was_full = (mq.size() == DEP);
      was_empty = (mq.size() == 0);
      if (flush) begin
        mq.delete();
        mb.delete();
        m_primed = 0;
        m_under = 0;
        m_cnt = 0;
        m_nf = '1;
      end else begin
        if (ls && !m_prev) m_cnt++;
        if (!ls && m_prev && m_primed) begin
          if (!was_empty) m_nf = mq.pop_front();
          else begin
            m_nf = '1;
            m_under = 1;
          end
        end else if (!m_primed && !was_empty && !ls) begin
          m_nf = mq.pop_front();
          m_primed = 1;
        end
        if (host_valid && !was_full) begin
          mb.push_back(host_data);
          if (mb.size() == NB) begin
            f = '0;
            foreach (mb[i]) f = (f << 8) | FB'(mb[i]);
            mq.push_back(f);
            mb.delete();
          end
        end
      end
      m_prev = ls;
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = latch_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_frame", next_frame, m_nf);
      check("m_level", level, mq.size());
      check("m_ready", host_ready, mq.size() != DEP);
      check("m_under", underflow, m_under);
      check("m_lcnt", latch_count, m_cnt);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    host_data = b;
    host_valid = 1'b1;
    while (!host_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_rdy", host_ready, 1'b1);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic latch_pulse(input int hi, input int lo);
    latch_in = 1'b1;
    repeat (hi) @(negedge clk);
    latch_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  function automatic logic [15:0] fr(input int k);
    return 16'(((2 * k) << 8) | (2 * k + 1));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int run;
    repeat (3) @(negedge clk);
    check("rst_frame", next_frame, 16'hFFFF);
    check("rst_level", level, 0);
    check("rst_lcnt", latch_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", host_ready, 1'b1);

    // unprimed latch: idle frame, no underflow
    latch_pulse(3, 4);
    check("t1_frame", next_frame, 16'hFFFF);
    check("t1_under", underflow, 1'b0);
    check("t1_lcnt", latch_count, 1);

    // priming then latch latency
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    repeat (2) @(negedge clk);
    check("t2_prime", next_frame, 16'h1234);
    check("t2_level", level, 1);
    latch_in = 1'b1;
    repeat (3) @(negedge clk);
    latch_in = 1'b0;
    repeat (2) @(negedge clk);
    check("t2_hold", next_frame, 16'h1234);
    @(negedge clk);
    check("t2_pop", next_frame, 16'h5678);
    check("t2_lcnt", latch_count, 2);
    repeat (2) @(negedge clk);

    // fill to full with back-to-back bytes
    do_flush();
    for (int k = 0; k <= DEP; k++) begin
      send_byte(8'(2 * k));
      send_byte(8'(2 * k + 1));
    end
    @(negedge clk);
    check("t3_level", level, DEP);
    check("t3_full", host_ready, 1'b0);
    check("t3_f0", next_frame, fr(0));
    fork
      send_byte(8'hAA);
      begin
        repeat (3) @(negedge clk);
        check("t3_stall", level, DEP);
        latch_pulse(3, 4);
      end
    join
    send_byte(8'hBB);
    check("t3_refull", level, DEP);
    for (int k = 1; k <= DEP; k++) begin
      check("t3_order", next_frame, fr(k));
      latch_pulse(3, 4);
    end
    check("t3_last", next_frame, 16'hAABB);

    // drain to empty -> underflow
    latch_pulse(3, 4);
    check("t4_idle", next_frame, 16'hFFFF);
    check("t4_under", underflow, 1'b1);
    send_byte(8'h9A);
    send_byte(8'hBC);
    repeat (2) @(negedge clk);
    check("t4_level", level, 1);
    check("t4_hold", next_frame, 16'hFFFF);
    latch_pulse(3, 4);
    check("t4_load", next_frame, 16'h9ABC);
    check("t4_sticky", underflow, 1'b1);

    // push and pop on the same edge at level 3
    do_flush();
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h77); send_byte(8'h88);
    @(negedge clk);
    check("t5_level3", level, 3);
    send_byte(8'h99);
    latch_in = 1'b1;
    repeat (3) @(negedge clk);
    latch_in = 1'b0;
    repeat (2) @(negedge clk);
    host_data = 8'hAA;
    host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    check("t5_same", level, 3);
    check("t5_f1", next_frame, 16'h3344);
    repeat (2) @(negedge clk);
    latch_pulse(3, 4);
    check("t5_f2", next_frame, 16'h5566);
    latch_pulse(3, 4);
    check("t5_f3", next_frame, 16'h7788);
    latch_pulse(3, 4);
    check("t5_f4", next_frame, 16'h99AA);

    // odd byte then flush mid-latch
    do_flush();
    send_byte(8'h01);
    latch_in = 1'b1;
    repeat (4) @(negedge clk);
    host_data = 8'h02;
    host_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    host_valid = 1'b0;
    check("t6_frame", next_frame, 16'hFFFF);
    check("t6_level", level, 0);
    check("t6_lcnt", latch_count, 0);
    latch_in = 1'b0;
    repeat (5) @(negedge clk);
    send_byte(8'h03);
    send_byte(8'h04);
    repeat (2) @(negedge clk);
    check("t6_pack", next_frame, 16'h0304);

    // odd byte then reset mid-latch
    send_byte(8'h05);
    latch_in = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6r_frame", next_frame, 16'hFFFF);
    check("t6r_level", level, 0);
    check("t6r_lcnt", latch_count, 0);
    check("t6r_under", underflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    latch_in = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h06);
    send_byte(8'h07);
    repeat (2) @(negedge clk);
    check("t6r_pack", next_frame, 16'h0607);

    // random traffic against the model
    run = 0;
    for (int c = 0; c < 5000; c++) begin
      host_valid = ($urandom_range(0, 2) != 0);
      host_data = 8'($urandom);
      flush = ($urandom_range(0, 299) == 0);
      if (run == 0) begin
        latch_in = ~latch_in;
        run = $urandom_range(1, 12);
      end
      run--;
      @(negedge clk);
    end
    host_valid = 1'b0;
    flush = 1'b0;
    latch_in = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
